// File: rtl/sap_memory_unit.sv
// SAP memory stage: MAR, MDR and a DEPTH x DATA_W RAM with a byte-stream programming port.
// Optional build macro MEM_CLEAR_ON_RESET_EN: rst_n also clears every RAM word.
module sap_memory_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16  // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic [ADDR_W-1:0] mar_q,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_pcnt;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_ram [DEPTH];

  logic              w_cpu_en;
  logic              w_prog_we;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic              w_pcnt_last;
  logic              w_unused_bus_hi;

  // CPU controls only act in RUN and only while the host is not requesting the port
  assign w_cpu_en    = (r_state == ST_RUN) && !prog_en;
  assign w_prog_we   = (r_state == ST_LOAD) && prog_valid;
  assign w_ram_we    = w_prog_we || (w_cpu_en && !ram_load_n);
  assign w_ram_addr  = (r_state == ST_LOAD) ? r_pcnt : r_mar;
  assign w_ram_wdata = (r_state == ST_LOAD) ? prog_data : r_mdr;
  assign w_pcnt_last = (r_pcnt == ADDR_W'(DEPTH - 1));
  assign w_unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];

  assign bus_drive  = w_cpu_en && !ram_en_n;
  assign bus_out    = bus_drive ? r_ram[r_mar] : '0;
  assign mar_q      = r_mar;
  assign prog_ready = (r_state == ST_LOAD);
  assign prog_done  = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pcnt  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (prog_en) begin
            r_state <= ST_LOAD;
            r_pcnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (!prog_en) begin
            r_state <= ST_RUN;
          end else if (prog_valid) begin
            // pcnt parks on the last word; DONE is entered instead of wrapping
            if (w_pcnt_last) r_state <= ST_DONE;
            else             r_pcnt  <= r_pcnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!prog_en) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (w_cpu_en && !mar_addr_load_n) r_mar <= bus_in[ADDR_W-1:0];
      if (w_cpu_en && !mar_mem_load_n)  r_mdr <= bus_in;
    end
  end

`ifdef MEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
    end else if (w_ram_we) begin
      r_ram[w_ram_addr] <= w_ram_wdata;
    end
  end
`else
  // Contents survive reset; power-up value is undefined until written
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
  end
`endif

endmodule

// File: tb/tb_sap_memory_unit.sv
// Directed bench for sap_memory_unit: CPU load/read paths, same-edge ordering, programming port, async reset.
module tb_sap_memory_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic [3:0] mar_q;
  logic       prog_en, prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready, prog_done;

  int n_cmp = 0;
  int n_err = 0;

  sap_memory_unit #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
    .mar_addr_load_n(mar_addr_load_n), .mar_mem_load_n(mar_mem_load_n),
    .ram_en_n(ram_en_n), .ram_load_n(ram_load_n),
    .bus_out(bus_out), .bus_drive(bus_drive), .mar_q(mar_q),
    .prog_en(prog_en), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .prog_done(prog_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    mar_addr_load_n = 1'b1;
    mar_mem_load_n  = 1'b1;
    ram_en_n        = 1'b1;
    ram_load_n      = 1'b1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    mar_mem_load_n = 1'b0; bus_in = data;
    cyc();
    mar_mem_load_n = 1'b1; mar_addr_load_n = 1'b0; bus_in = {4'h0, addr};
    cyc();
    mar_addr_load_n = 1'b1; ram_load_n = 1'b0;
    cyc();
    ram_load_n = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    mar_addr_load_n = 1'b0; bus_in = {4'h0, addr};
    cyc();
    mar_addr_load_n = 1'b1; ram_en_n = 1'b0;
    #1;
    chk(tag, bus_out, exp);
    ram_en_n = 1'b1;
  endtask

  // Streams n bytes base..base+n-1 while hammering the CPU controls
  task automatic stream_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1; prog_data = base + 8'(i);
      mar_addr_load_n = 1'b0; mar_mem_load_n = 1'b0; ram_load_n = 1'b0; ram_en_n = 1'b0;
      bus_in = 8'hFF;
      #1;
      chk("load_bus_drive", bus_drive, 1'b0);
      cyc();
    end
    prog_valid = 1'b0;
    idle_ctl();
  endtask

  initial begin
    rst_n = 1'b0; bus_in = 8'h00; prog_en = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
    idle_ctl();
    #12;
    chk("rst_mar_q", mar_q, 4'h0);
    chk("rst_bus_drive", bus_drive, 1'b0);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_prog_ready", prog_ready, 1'b0);
    chk("rst_prog_done", prog_done, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic write/read
    write_word(4'd3, 8'h5C);
    write_word(4'd10, 8'h3C);
    mar_addr_load_n = 1'b0; bus_in = 8'h0A;
    cyc();
    mar_addr_load_n = 1'b1; ram_en_n = 1'b0;
    #1;
    chk("mar_q_A", mar_q, 4'hA);
    chk("ce_drive", bus_drive, 1'b1);
    chk("ram10", bus_out, 8'h3C);
    ram_en_n = 1'b1;
    #1;
    chk("ce_off_bus_out", bus_out, 8'h00);
    read_chk("ram3", 4'd3, 8'h5C);

    // L_MA together with L_R writes at the old MAR
    write_word(4'd7, 8'h77);
    mar_mem_load_n = 1'b0; bus_in = 8'h11;
    cyc();
    mar_mem_load_n = 1'b1; mar_addr_load_n = 1'b0; bus_in = 8'h02;
    cyc();
    bus_in = 8'h07; ram_load_n = 1'b0;
    cyc();
    idle_ctl();
    chk("sim_mar_q", mar_q, 4'h7);
    ram_en_n = 1'b0;
    #1;
    chk("sim_ram7_kept", bus_out, 8'h77);
    ram_en_n = 1'b1;
    read_chk("sim_ram2", 4'd2, 8'h11);

    // L_MD with L_R writes old MDR; CE with L_R shows the old word
    mar_mem_load_n = 1'b0; bus_in = 8'h99; ram_load_n = 1'b0; ram_en_n = 1'b0;
    #1;
    chk("ce_lr_old_word", bus_out, 8'h11);
    cyc();
    idle_ctl(); ram_en_n = 1'b0;
    #1;
    chk("lr_old_mdr", bus_out, 8'h11);
    ram_en_n = 1'b1; ram_load_n = 1'b0;
    cyc();
    idle_ctl(); ram_en_n = 1'b0;
    #1;
    chk("lr_new_mdr", bus_out, 8'h99);
    ram_en_n = 1'b1;

    // Full programming load 00..0F
    prog_en = 1'b1;
    #1;
    chk("pre_load_ready", prog_ready, 1'b0);
    cyc();
    chk("load_ready", prog_ready, 1'b1);
    stream_bytes(8'h00, 15);
    prog_valid = 1'b1; prog_data = 8'h0F;
    #1;
    chk("last_byte_not_done", prog_done, 1'b0);
    cyc();
    prog_valid = 1'b0;
    chk("done_after_16", prog_done, 1'b1);
    chk("done_ready_low", prog_ready, 1'b0);
    cyc();
    chk("done_hold", prog_done, 1'b1);
    prog_en = 1'b0;
    cyc();
    chk("done_exit", prog_done, 1'b0);
    chk("mar_untouched", mar_q, 4'h2);
    for (int i = 0; i < 16; i++) read_chk("prog1_ram", 4'(i), 8'(i));

    // Aborted load then full reload
    prog_en = 1'b1;
    cyc();
    stream_bytes(8'hA0, 5);
    prog_en = 1'b0;
    cyc();
    chk("abort_ready_low", prog_ready, 1'b0);
    chk("abort_done_low", prog_done, 1'b0);
    for (int i = 0; i < 5; i++) read_chk("abort_ram", 4'(i), 8'hA0 + 8'(i));
    read_chk("abort_ram5_kept", 4'd5, 8'h05);
    prog_en = 1'b1;
    cyc();
    stream_bytes(8'hB0, 16);
    chk("reload_done", prog_done, 1'b1);
    prog_en = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) read_chk("prog2_ram", 4'(i), 8'hB0 + 8'(i));

    // Asynchronous reset mid-load
    prog_en = 1'b1;
    cyc();
    stream_bytes(8'hC0, 3);
    chk("midload_ready", prog_ready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", prog_ready, 1'b0);
    chk("async_rst_mar", mar_q, 4'h0);
    prog_en = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();
`ifdef MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 4; i++) read_chk("rst_clear_ram", 4'(i), 8'h00);
    read_chk("rst_clear_ram15", 4'd15, 8'h00);
`else
    for (int i = 0; i < 3; i++) read_chk("rst_keep_ram", 4'(i), 8'hC0 + 8'(i));
    read_chk("rst_keep_ram3", 4'd3, 8'hB3);
    read_chk("rst_keep_ram15", 4'd15, 8'hBF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
